// File: rtl/fifo_word_packer.sv
// Pops bytes from an 8-bit FIFO and packs BYTES_PER_WORD of them, little-endian, into masked words.
// Define PACKER_TIMEOUT_EN to auto-flush a partial word after TIMEOUT_CYCLES idle cycles.
module fifo_word_packer #(
   parameter int unsigned BYTES_PER_WORD = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [7:0]                  fifo_data_out,
   input  logic                        fifo_empty,
   output logic                        fifo_rn,
   input  logic                        flush,
   output logic [8*BYTES_PER_WORD-1:0] out_data,
   output logic [BYTES_PER_WORD-1:0]   out_mask,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);

   localparam int unsigned CW = $clog2(BYTES_PER_WORD + 1);
   localparam int unsigned DW = 8 * BYTES_PER_WORD;
   localparam logic [CW-1:0] FullCnt = CW'(BYTES_PER_WORD);
   localparam logic [CW-1:0] OneCnt  = CW'(1);

   if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8) begin : gen_bad_width
      $error("fifo_word_packer: BYTES_PER_WORD must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gen_bad_timeout
      $error("fifo_word_packer: TIMEOUT_CYCLES must be 1..255");
   end

   logic [CW-1:0] issued_q, issued_d;
   logic [CW-1:0] cap_q, cap_d;
   logic          rd_pending_q;
   logic          flush_pending_q, flush_pending_d;
   logic [DW-1:0] asm_q, asm_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [BYTES_PER_WORD-1:0] out_mask_q, out_mask_d;
   logic          out_valid_q, out_valid_d;
   logic          word_done;
   logic          out_free;
   logic          timeout_hit;

   assign fifo_rn = !fifo_empty && (issued_q < FullCnt) && !flush_pending_q && !reset;

`ifdef PACKER_TIMEOUT_EN
   logic [7:0] idle_q, idle_d;

   // Counts only while a partial word sits with nothing in flight and nothing requested.
   always_comb begin
      idle_d      = '0;
      timeout_hit = 1'b0;
      if (cap_q != '0 && !rd_pending_q && !fifo_rn && !flush_pending_q) begin
         if (idle_q == 8'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
         end else begin
            idle_d = idle_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      issued_d        = issued_q;
      cap_d           = cap_q;
      asm_d           = asm_q;
      flush_pending_d = flush_pending_q;
      out_data_d      = out_data_q;
      out_mask_d      = out_mask_q;
      out_valid_d     = out_valid_q;
      out_free        = !out_valid_q || out_ready;

      if (fifo_rn) begin
         issued_d = issued_q + OneCnt;
      end

      if (rd_pending_q) begin
         for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (cap_q == CW'(i)) begin
               asm_d[8*i +: 8] = fifo_data_out;
            end
         end
         cap_d = cap_q + OneCnt;
      end

      // Flush on an empty or already-full word is meaningless and dropped.
      if ((flush || timeout_hit) && issued_q != '0 && issued_q < FullCnt) begin
         flush_pending_d = 1'b1;
      end

      word_done = (cap_d == FullCnt) || (flush_pending_q && !rd_pending_q && cap_q != '0);

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (word_done && out_free) begin
         out_valid_d = 1'b1;
         out_data_d  = asm_d;
         for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            out_mask_d[i] = (CW'(i) < cap_d);
         end
         // Clearing the assembly register keeps unused lanes of the next word at zero.
         asm_d           = '0;
         cap_d           = '0;
         issued_d        = '0;
         flush_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         issued_q        <= '0;
         cap_q           <= '0;
         rd_pending_q    <= 1'b0;
         flush_pending_q <= 1'b0;
         asm_q           <= '0;
         out_data_q      <= '0;
         out_mask_q      <= '0;
         out_valid_q     <= 1'b0;
      end else begin
         issued_q        <= issued_d;
         cap_q           <= cap_d;
         rd_pending_q    <= fifo_rn;
         flush_pending_q <= flush_pending_d;
         asm_q           <= asm_d;
         out_data_q      <= out_data_d;
         out_mask_q      <= out_mask_d;
         out_valid_q     <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_mask  = out_mask_q;
   assign out_valid = out_valid_q;
   assign busy      = out_valid_q || rd_pending_q || issued_q != '0 || cap_q != '0;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (BYTES_PER_WORD=4) with a behavioural registered-read FIFO.
module tb_fifo_word_packer;

   logic        clock;
   logic        reset;
   logic [7:0]  fifo_data_out;
   logic        fifo_empty;
   logic        fifo_rn;
   logic        flush;
   logic [31:0] out_data;
   logic [3:0]  out_mask;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int errors = 0;
   int checks = 0;

   fifo_word_packer #(
      .BYTES_PER_WORD(4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .fifo_data_out(fifo_data_out),
      .fifo_empty   (fifo_empty),
      .fifo_rn      (fifo_rn),
      .flush        (flush),
      .out_data     (out_data),
      .out_mask     (out_mask),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // FIFO model: read data is registered and valid the cycle after fifo_rn.
   logic [7:0]  mem [0:63];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);
   initial fifo_data_out = 8'h00;

   always @(posedge clock) begin
      if (fifo_rn) begin
         fifo_data_out <= mem[rd_ptr[5:0]];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[5:0]] = b;
      wr_ptr++;
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rn_cnt;
      int seen;
      int first;
      logic [31:0] first_data;
      logic [3:0]  first_mask;

      reset     = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_rn", fifo_rn, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_mask", out_mask, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      step();

      // Basic word, latency and one-cycle valid.
      out_ready = 1'b1;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      #1;
      for (int c = 0; c < 4; c++) begin
         chk("t1_rn_on", fifo_rn, 1);
         step();
      end
      chk("t1_rn_off", fifo_rn, 0);
      chk("t1_valid_c4", out_valid, 0);
      step();
      chk("t1_valid_c5", out_valid, 1);
      chk("t1_data", out_data, 32'h44332211);
      chk("t1_mask", out_mask, 4'b1111);
      step();
      chk("t1_valid_c6", out_valid, 0);
      chk("t1_busy", busy, 0);

      // Backpressure: second word waits in assembly, no bubble on accept.
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      #1;
      rn_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 5) chk("t2_first_word", out_data, 32'h04030201);
         if (c == 12) begin
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_data", out_data, 32'h04030201);
            chk("t2_hold_rn", fifo_rn, 0);
         end
         rn_cnt += int'(fifo_rn);
         step();
      end
      chk("t2_rn_count", rn_cnt, 8);
      chk("t2_c20_data", out_data, 32'h04030201);
      out_ready = 1'b1;
      step();
      chk("t2_second_valid", out_valid, 1);
      chk("t2_second_data", out_data, 32'h08070605);
      chk("t2_second_mask", out_mask, 4'b1111);
      step();
      chk("t2_drained", out_valid, 0);

      // Flush of a two-byte partial word, then flush on an idle packer.
      push(8'hAA); push(8'hBB);
      #1;
      for (int c = 0; c < 4; c++) step();
      chk("t3_no_early", out_valid, 0);
      chk("t3_busy_partial", busy, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t3_valid_c5", out_valid, 0);
      step();
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, 32'h0000BBAA);
      chk("t3_mask", out_mask, 4'b0011);
      step();
      chk("t3_after_valid", out_valid, 0);
      chk("t3_after_busy", busy, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         seen += int'(out_valid);
         step();
      end
      chk("t3_idle_flush_none", seen, 0);
      chk("t3_idle_busy", busy, 0);

      // Flush coincident with the third read; fourth byte must wait.
      push(8'h10); push(8'h20); push(8'h30); push(8'h40);
      #1;
      step();
      step();
      chk("t4_rn_c2", fifo_rn, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t4_rn_blocked_c3", fifo_rn, 0);
      step();
      chk("t4_rn_blocked_c4", fifo_rn, 0);
      chk("t4_valid_c4", out_valid, 0);
      step();
      chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, 32'h00302010);
      chk("t4_mask", out_mask, 4'b0111);
      chk("t4_next_rn", fifo_rn, 1);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      chk("t4_tail_valid", out_valid, 1);
      chk("t4_tail_data", out_data, 32'h00000040);
      chk("t4_tail_mask", out_mask, 4'b0001);
      step();
      chk("t4_tail_done", out_valid, 0);

      // Reset with two bytes captured and one in flight.
      push(8'hC1); push(8'hC2); push(8'hC3);
      #1;
      step();
      step();
      step();
      chk("t5_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      chk("t5_rn", fifo_rn, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_data", out_data, 0);
      chk("t5_mask", out_mask, 0);
      chk("t5_busy", busy, 0);
      step();
      step();
      reset = 1'b0;
      push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
      #1;
      for (int c = 0; c < 5; c++) step();
      chk("t5_clean_valid", out_valid, 1);
      chk("t5_clean_data", out_data, 32'hD4D3D2D1);
      chk("t5_clean_mask", out_mask, 4'b1111);
      step();
      chk("t5_clean_done", out_valid, 0);

      // Single stranded byte: auto-flush only when the timeout is built in.
      push(8'h5A);
      #1;
      first      = -1;
      seen       = 0;
      first_data = '0;
      first_mask = '0;
      for (int c = 0; c < 100; c++) begin
         if (out_valid) begin
            seen++;
            if (first < 0) begin
               first      = c;
               first_data = out_data;
               first_mask = out_mask;
            end
         end
         step();
      end
`ifdef PACKER_TIMEOUT_EN
      chk("t6_timeout_window", (first >= 17 && first <= 22), 1);
      chk("t6_timeout_data", first_data, 32'h0000005A);
      chk("t6_timeout_mask", first_mask, 4'b0001);
      chk("t6_timeout_once", seen, 1);
`else
      chk("t6_no_output", seen, 0);
      chk("t6_still_busy", busy, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
